// File: rtl/cdb_arbiter_if.sv
// Result bus between the functional units and the CDB arbiter.
// Defaults SCALAR_WIDTH/PREG_IDX_WIDTH unless the defines header set them.
`ifndef SCALAR_WIDTH
`define SCALAR_WIDTH 2
`endif
`ifndef PREG_IDX_WIDTH
`define PREG_IDX_WIDTH 6
`endif

interface cdb_arbiter_if #(
  parameter int NUM_FU = 4,
  parameter int XLEN   = 32
);
  localparam int SW = `SCALAR_WIDTH;
  localparam int PW = `PREG_IDX_WIDTH;

  logic                            squash;
  logic [NUM_FU-1:0]               fu_valid;
  logic [NUM_FU-1:0][PW-1:0]       fu_tag;
  logic [NUM_FU-1:0][XLEN-1:0]     fu_value;
  logic [NUM_FU-1:0]               fu_ready;
  logic [SW-1:0]                   cdb_valid;
  logic [SW-1:0][PW-1:0]           cdb_tag;
  logic [SW-1:0][XLEN-1:0]         cdb_value;

  modport master (
    output squash, fu_valid, fu_tag, fu_value,
    input  fu_ready, cdb_valid, cdb_tag, cdb_value
  );

  modport slave (
    input  squash, fu_valid, fu_tag, fu_value,
    output fu_ready, cdb_valid, cdb_tag, cdb_value
  );
endinterface

// File: rtl/cdb_arbiter.sv
// CDB arbiter: per-FU hold buffers, up to SCALAR_WIDTH broadcasts per cycle.
// CDB_ROUND_ROBIN_EN selects round-robin; otherwise fixed low-index priority.
`ifndef SCALAR_WIDTH
`define SCALAR_WIDTH 2
`endif
`ifndef PREG_IDX_WIDTH
`define PREG_IDX_WIDTH 6
`endif

module cdb_arbiter #(
  parameter int NUM_FU = 4,
  parameter int XLEN   = 32
) (
  input  logic          clock,
  input  logic          reset,
  cdb_arbiter_if.slave  bus
);
  localparam int SW = `SCALAR_WIDTH;
  localparam int PW = `PREG_IDX_WIDTH;
  localparam int IW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [NUM_FU-1:0]           hold_valid;
  logic [NUM_FU-1:0][PW-1:0]   hold_tag;
  logic [NUM_FU-1:0][XLEN-1:0] hold_value;

  logic [NUM_FU-1:0]           grant;
  logic [SW-1:0]               lane_hit;
  logic [SW-1:0][IW-1:0]       lane_idx;
  logic [IW-1:0]               last_idx;
  logic [IW-1:0]               base;
  logic [NUM_FU-1:0]           fu_ready;

  logic [SW-1:0]               cdb_valid;
  logic [SW-1:0][PW-1:0]       cdb_tag;
  logic [SW-1:0][XLEN-1:0]     cdb_value;

  function automatic logic [IW-1:0] wrap_idx(
    input logic [IW-1:0] p,
    input int            k
  );
    int s;
    s = int'(p) + k;
    if (s >= NUM_FU) s = s - NUM_FU;
    return IW'(s);
  endfunction

`ifdef CDB_ROUND_ROBIN_EN
  logic [IW-1:0] rr_ptr;

  // Move the search start just past the last FU granted.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr <= '0;
    end else if (!bus.squash && lane_hit[0]) begin
      rr_ptr <= wrap_idx(last_idx, 1);
    end
  end

  assign base = rr_ptr;
`else
  assign base = '0;
`endif

  // Walk FUs from base, filling lanes in order with held results.
  always_comb begin
    logic          taken;
    logic [IW-1:0] idx;
    grant    = '0;
    lane_hit = '0;
    lane_idx = '0;
    last_idx = '0;
    taken    = 1'b0;
    idx      = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      idx   = wrap_idx(base, k);
      taken = 1'b0;
      for (int l = 0; l < SW; l++) begin
        if (hold_valid[idx] && !taken && !lane_hit[l]) begin
          lane_hit[l] = 1'b1;
          lane_idx[l] = idx;
          grant[idx]  = 1'b1;
          last_idx    = idx;
          taken       = 1'b1;
        end
      end
    end
  end

  // An entry leaving this cycle frees its slot for a same-cycle refill.
  assign fu_ready     = bus.squash ? '0 : (~hold_valid | grant);
  assign bus.fu_ready = fu_ready;

  // Capture offered results; drop entries once they are broadcast.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hold_valid <= '0;
      hold_tag   <= '0;
      hold_value <= '0;
    end else if (bus.squash) begin
      hold_valid <= '0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (bus.fu_valid[i] && fu_ready[i]) begin
          hold_valid[i] <= 1'b1;
          hold_tag[i]   <= bus.fu_tag[i];
          hold_value[i] <= bus.fu_value[i];
        end else if (grant[i]) begin
          hold_valid[i] <= 1'b0;
        end
      end
    end
  end

  // Register the granted entries onto the broadcast lanes.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cdb_valid <= '0;
      cdb_tag   <= '0;
      cdb_value <= '0;
    end else if (bus.squash) begin
      cdb_valid <= '0;
      cdb_tag   <= '0;
      cdb_value <= '0;
    end else begin
      for (int l = 0; l < SW; l++) begin
        cdb_valid[l] <= lane_hit[l];
        cdb_tag[l]   <= lane_hit[l] ? hold_tag[lane_idx[l]] : '0;
        cdb_value[l] <= lane_hit[l] ? hold_value[lane_idx[l]] : '0;
      end
    end
  end

  assign bus.cdb_valid = cdb_valid;
  assign bus.cdb_tag   = cdb_tag;
  assign bus.cdb_value = cdb_value;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: random and directed offers vs. a queue-based model.
// Follows CDB_ROUND_ROBIN_EN to pick the reference arbitration rule.
module tb_cdb_arbiter;
  localparam int N  = 4;
  localparam int XL = 32;
  localparam int P  = 6;
`ifdef CDB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  cdb_arbiter_if #(.NUM_FU(N), .XLEN(XL)) bus ();

  cdb_arbiter #(.NUM_FU(N), .XLEN(XL)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int          due;
    logic [1:0]  v;
    logic [5:0]  t0, t1;
    logic [31:0] d0, d1;
  } exp_t;

  exp_t sbq[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;

  bit          mhv[N];
  logic [5:0]  mtag[N];
  logic [31:0] mval[N];
  int          mptr;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < N; i++) mhv[i] = 1'b0;
    mptr = 0;
  endfunction

  // Held results in search order from mptr; first two win.
  function automatic void arb(output int l0, output int l1, output int n);
    int i;
    n = 0; l0 = 0; l1 = 0;
    for (int k = 0; k < N; k++) begin
      i = (mptr + k) % N;
      if (mhv[i] && n < 2) begin
        if (n == 0) l0 = i;
        else l1 = i;
        n++;
      end
    end
  endfunction

  task automatic tick();
    int l0, l1, n;
    bit g[N];
    logic [N-1:0] rdy;
    exp_t e;
    arb(l0, l1, n);
    for (int i = 0; i < N; i++) g[i] = 1'b0;
    if (n > 0) g[l0] = 1'b1;
    if (n > 1) g[l1] = 1'b1;
    for (int i = 0; i < N; i++)
      rdy[i] = !bus.squash && (!mhv[i] || g[i]);
    #1 chk("fu_ready", 64'(bus.fu_ready), 64'(rdy));
    @(posedge clock);
    if (reset) begin
      if (bus.squash) begin
        for (int i = 0; i < N; i++) mhv[i] = 1'b0;
      end else begin
        if (n > 0) begin
          e.due = cyc + 1;
          e.v   = (n == 2) ? 2'b11 : 2'b01;
          e.t0  = mtag[l0];
          e.d0  = mval[l0];
          e.t1  = (n == 2) ? mtag[l1] : 6'd0;
          e.d1  = (n == 2) ? mval[l1] : 32'd0;
          sbq.push_back(e);
        end
        for (int i = 0; i < N; i++) begin
          if (bus.fu_valid[i] && rdy[i]) begin
            mhv[i]  = 1'b1;
            mtag[i] = bus.fu_tag[i];
            mval[i] = bus.fu_value[i];
          end else if (g[i]) begin
            mhv[i] = 1'b0;
          end
        end
        if (RR && n > 0) mptr = (((n == 2) ? l1 : l0) + 1) % N;
      end
    end
    @(negedge clock);
  endtask

  task automatic idle(input int cycles);
    bus.fu_valid = '0;
    bus.squash   = 1'b0;
    repeat (cycles) tick();
  endtask

  task automatic offer(input logic [3:0] v, input logic [5:0] tb0,
                       input logic [31:0] vb0);
    bus.fu_valid = v;
    for (int i = 0; i < N; i++) begin
      bus.fu_tag[i]   = tb0 + 6'(i);
      bus.fu_value[i] = vb0 + 32'(i);
    end
    tick();
  endtask

  // Monitor: a due scoreboard entry must match exactly, otherwise idle.
  always @(negedge clock) begin
    exp_t e;
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      e = sbq.pop_front();
      chk("cdb_valid", 64'(bus.cdb_valid), 64'(e.v));
      chk("cdb_tag0", 64'(bus.cdb_tag[0]), 64'(e.t0));
      chk("cdb_tag1", 64'(bus.cdb_tag[1]), 64'(e.t1));
      chk("cdb_value0", 64'(bus.cdb_value[0]), 64'(e.d0));
      if (e.v[1]) chk("cdb_value1", 64'(bus.cdb_value[1]), 64'(e.d1));
    end else begin
      chk("cdb_idle_valid", 64'(bus.cdb_valid), 64'd0);
      chk("cdb_idle_tag", 64'(bus.cdb_tag), 64'd0);
    end
  end

  initial begin
    bus.squash   = 1'b0;
    bus.fu_valid = '0;
    bus.fu_tag   = '0;
    bus.fu_value = '0;
    model_clear();

    // Reset state; offers during reset must not be captured.
    repeat (2) @(negedge clock);
    bus.fu_valid = 4'hF;
    #1;
    chk("rst_ready", 64'(bus.fu_ready), 64'hF);
    chk("rst_valid", 64'(bus.cdb_valid), 64'd0);
    chk("rst_tag", 64'(bus.cdb_tag), 64'd0);
    chk("rst_value", 64'(bus.cdb_value), 64'd0);
    @(negedge clock);
    bus.fu_valid = '0;
    reset = 1'b1;
    model_clear();
    idle(3);

    // Single result from FU2.
    bus.fu_valid = 4'b0100;
    bus.fu_tag[2] = 6'd17;
    bus.fu_value[2] = 32'hAB;
    tick();
    idle(4);

    // All four FUs at once, tags 1..4.
    offer(4'hF, 6'd1, 32'h100);
    idle(4);

    // Sustained offers from everyone (fairness / starvation).
    for (int c = 0; c < 10; c++) offer(4'hF, 6'(8 + c * 4), 32'(c * 16));
    idle(6);

    // Squash with three held entries and both lanes busy.
    offer(4'hF, 6'd20, 32'h200);
    offer(4'b0001, 6'd30, 32'h300);
    bus.fu_valid = 4'b0010;
    bus.squash = 1'b1;
    tick();
    bus.squash = 1'b0;
    bus.fu_valid = 4'b0010;
    bus.fu_tag[1] = 6'd9;
    bus.fu_value[1] = 32'h99;
    tick();
    idle(4);

    // Tag 0 is ordinary data.
    bus.fu_valid = 4'b1000;
    bus.fu_tag[3] = 6'd0;
    bus.fu_value[3] = 32'h5A5A;
    tick();
    idle(3);

    // Random traffic with occasional squash.
    for (int c = 0; c < 300; c++) begin
      bus.fu_valid = 4'($urandom);
      bus.squash   = ($urandom_range(0, 19) == 0);
      for (int i = 0; i < N; i++) begin
        bus.fu_tag[i]   = 6'($urandom);
        bus.fu_value[i] = $urandom;
      end
      tick();
    end
    idle(6);

    // Asynchronous reset mid-cycle with entries held.
    offer(4'hF, 6'd40, 32'h400);
    bus.fu_valid = '0;
    tick();
    #2 reset = 1'b0;
    sbq.delete();
    model_clear();
    #1;
    chk("arst_valid", 64'(bus.cdb_valid), 64'd0);
    chk("arst_tag", 64'(bus.cdb_tag), 64'd0);
    chk("arst_value", 64'(bus.cdb_value), 64'd0);
    chk("arst_ready", 64'(bus.fu_ready), 64'hF);
    @(negedge clock);
    reset = 1'b1;
    idle(6);

    chk("sb_empty", 64'(sbq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
